// File: rtl/div_arb_pkg.sv
// Shared types and defaults for the divider arbiter.
package div_arb_pkg;

    localparam int DIV_ARB_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        RETURN = 2'd3
    } div_arb_state_t;

    typedef logic grant_t;

endpackage

// File: rtl/div_arbiter_chk.sv
// Protocol properties of the divider arbiter.
module div_arbiter_chk (
    input logic clk_in,
    input logic rst_in,
    input logic issue_i,
    input logic div_busy_i,
    input logic idle_i,
    input logic ready0_i,
    input logic ready1_i
);

    a_issue_div_idle: assert property (@(posedge clk_in) disable iff (rst_in) issue_i |-> !div_busy_i);
    a_one_ready:      assert property (@(posedge clk_in) disable iff (rst_in) !(ready0_i && ready1_i));
    a_ready_in_idle:  assert property (@(posedge clk_in) disable iff (rst_in) (ready0_i || ready1_i) |-> idle_i);

endmodule

// File: rtl/divider.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, result WIDTH+1 cycles after start.
module divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             data_valid_in,
    input  logic [WIDTH-1:0] dividend_in,
    input  logic [WIDTH-1:0] divisor_in,
    output logic             data_valid_out,
    output logic [WIDTH-1:0] quotient_out,
    output logic [WIDTH-1:0] remainder_out,
    output logic             error_out,
    output logic             busy_out
);

    localparam int CW = $clog2(WIDTH + 1);

    logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dsr_q, dsr_d;
    logic [WIDTH:0]   trial_s, diff_s;

    // Shift one dividend bit into the partial remainder and subtract when it fits.
    always_comb begin
        busy_d  = busy_q;
        count_d = count_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dsr_d   = dsr_q;
        err_d   = err_q;
        done_d  = 1'b0;
        trial_s = {rem_q, quo_q[WIDTH-1]};
        diff_s  = trial_s - {1'b0, dsr_q};
        if (busy_q) begin
            if (trial_s >= {1'b0, dsr_q}) begin
                rem_d = diff_s[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = trial_s[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            count_d = count_q - CW'(1);
            if (count_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                done_d = 1'b0;
            end
        end else if (data_valid_in) begin
            busy_d  = 1'b1;
            count_d = CW'(WIDTH);
            quo_d   = dividend_in;
            rem_d   = {WIDTH{1'b0}};
            dsr_d   = divisor_in;
            err_d   = (divisor_in == {WIDTH{1'b0}});
        end else begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            count_q <= {CW{1'b0}};
            quo_q   <= {WIDTH{1'b0}};
            rem_q   <= {WIDTH{1'b0}};
            dsr_q   <= {WIDTH{1'b0}};
        end else begin
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            count_q <= count_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dsr_q   <= dsr_d;
        end
    end

    assign data_valid_out = done_q;
    assign quotient_out   = quo_q;
    assign remainder_out  = rem_q;
    assign error_out      = err_q;
    assign busy_out       = busy_q;

endmodule

// File: rtl/div_arbiter.sv
// Shares one iterative divider between two requesters, one job at a time.
// Define DIV_ARB_ROUND_ROBIN_EN for round-robin tie-break; otherwise requester 0 has fixed priority.
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int WIDTH = DIV_ARB_WIDTH
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             req0_valid_in,
    input  logic [WIDTH-1:0] req0_dividend_in,
    input  logic [WIDTH-1:0] req0_divisor_in,
    output logic             req0_ready_out,
    input  logic             req1_valid_in,
    input  logic [WIDTH-1:0] req1_dividend_in,
    input  logic [WIDTH-1:0] req1_divisor_in,
    output logic             req1_ready_out,
    output logic [WIDTH-1:0] res0_quotient_out,
    output logic [WIDTH-1:0] res0_remainder_out,
    output logic             res0_error_out,
    output logic             res0_valid_out,
    output logic [WIDTH-1:0] res1_quotient_out,
    output logic [WIDTH-1:0] res1_remainder_out,
    output logic             res1_error_out,
    output logic             res1_valid_out,
    output logic             busy_out
);

    div_arb_state_t   state_q, state_d;
    grant_t           grant_q, grant_d, grant_sel_s, res_id_s;
    logic [WIDTH-1:0] dividend_q, dividend_d, divisor_q, divisor_d;
    logic [WIDTH-1:0] sel_dividend_s, sel_divisor_s, res_quo_s, res_rem_s;
    logic             res_err_s, load_res_s, accept_s, div_start_s;
    logic [WIDTH-1:0] res0_quo_q, res0_rem_q, res1_quo_q, res1_rem_q;
    logic             res0_err_q, res1_err_q, res0_valid_q, res1_valid_q, busy_q;
    logic             div_valid_s, div_err_s, div_busy_s;
    logic [WIDTH-1:0] div_quo_s, div_rem_s;

`ifdef DIV_ARB_ROUND_ROBIN_EN
    grant_t last_grant_q;

    // Remember who won the last acceptance; starts at 1 so requester 0 wins the first tie.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            last_grant_q <= 1'b1;
        end else if (accept_s) begin
            last_grant_q <= grant_sel_s;
        end
    end
`endif

    always_comb begin
        grant_sel_s = 1'b0;
        if (req0_valid_in && req1_valid_in) begin
`ifdef DIV_ARB_ROUND_ROBIN_EN
            grant_sel_s = ~last_grant_q;
`else
            grant_sel_s = 1'b0;
`endif
        end else if (req0_valid_in) begin
            grant_sel_s = 1'b0;
        end else begin
            grant_sel_s = 1'b1;
        end
    end

    assign accept_s       = (state_q == IDLE) && (req0_valid_in || req1_valid_in);
    assign req0_ready_out = accept_s && (grant_sel_s == 1'b0);
    assign req1_ready_out = accept_s && (grant_sel_s == 1'b1);
    assign sel_dividend_s = grant_sel_s ? req1_dividend_in : req0_dividend_in;
    assign sel_divisor_s  = grant_sel_s ? req1_divisor_in  : req0_divisor_in;
    assign div_start_s    = (state_q == ISSUE);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        load_res_s = 1'b0;
        res_id_s   = grant_q;
        res_quo_s  = {WIDTH{1'b0}};
        res_rem_s  = {WIDTH{1'b0}};
        res_err_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    grant_d    = grant_sel_s;
                    dividend_d = sel_dividend_s;
                    divisor_d  = sel_divisor_s;
                    // A zero divisor never reaches the divider; its result is known now.
                    if (sel_divisor_s == {WIDTH{1'b0}}) begin
                        state_d    = RETURN;
                        load_res_s = 1'b1;
                        res_id_s   = grant_sel_s;
                        res_err_s  = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (div_valid_s) begin
                    state_d    = RETURN;
                    load_res_s = 1'b1;
                    res_quo_s  = div_quo_s;
                    res_rem_s  = div_rem_s;
                    res_err_s  = div_err_s | (divisor_q == {WIDTH{1'b0}});
                end else begin
                    state_d = WAIT;
                end
            end
            RETURN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            grant_q    <= 1'b0;
            dividend_q <= {WIDTH{1'b0}};
            divisor_q  <= {WIDTH{1'b0}};
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            busy_q     <= (state_d != IDLE);
        end
    end

    // Result registers load on entry to RETURN so the valid pulse and the data appear together.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            res0_quo_q   <= {WIDTH{1'b0}};
            res0_rem_q   <= {WIDTH{1'b0}};
            res0_err_q   <= 1'b0;
            res0_valid_q <= 1'b0;
            res1_quo_q   <= {WIDTH{1'b0}};
            res1_rem_q   <= {WIDTH{1'b0}};
            res1_err_q   <= 1'b0;
            res1_valid_q <= 1'b0;
        end else begin
            res0_valid_q <= load_res_s && (res_id_s == 1'b0);
            res1_valid_q <= load_res_s && (res_id_s == 1'b1);
            if (load_res_s && (res_id_s == 1'b0)) begin
                res0_quo_q <= res_quo_s;
                res0_rem_q <= res_rem_s;
                res0_err_q <= res_err_s;
            end
            if (load_res_s && (res_id_s == 1'b1)) begin
                res1_quo_q <= res_quo_s;
                res1_rem_q <= res_rem_s;
                res1_err_q <= res_err_s;
            end
        end
    end

    assign res0_quotient_out  = res0_quo_q;
    assign res0_remainder_out = res0_rem_q;
    assign res0_error_out     = res0_err_q;
    assign res0_valid_out     = res0_valid_q;
    assign res1_quotient_out  = res1_quo_q;
    assign res1_remainder_out = res1_rem_q;
    assign res1_error_out     = res1_err_q;
    assign res1_valid_out     = res1_valid_q;
    assign busy_out           = busy_q;

    divider #(.WIDTH(WIDTH)) u_divider (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .data_valid_in  (div_start_s),
        .dividend_in    (dividend_q),
        .divisor_in     (divisor_q),
        .data_valid_out (div_valid_s),
        .quotient_out   (div_quo_s),
        .remainder_out  (div_rem_s),
        .error_out      (div_err_s),
        .busy_out       (div_busy_s)
    );

    div_arbiter_chk u_chk (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .issue_i    (div_start_s),
        .div_busy_i (div_busy_s),
        .idle_i     (state_q == IDLE),
        .ready0_i   (req0_ready_out),
        .ready1_i   (req1_ready_out)
    );

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter: directed scenarios plus randomized jobs against a quotient/grant model.
module tb_div_arbiter;

    localparam int W       = 32;
    // The divider raises data_valid_out WIDTH+1 cycles after its start cycle.
    localparam int DIV_LAT = W + 1;
    // Acceptance in A, ISSUE in A+1, divider done in A+1+DIV_LAT, pulse one cycle later.
    localparam int RES_LAT = DIV_LAT + 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         r0v = 1'b0, r1v = 1'b0;
    logic [W-1:0] r0a = '0, r0b = '0, r1a = '0, r1b = '0;
    logic         rdy0, rdy1, v0, v1, e0, e1, busy;
    logic [W-1:0] q0, q1, m0, m1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ready_viol = 0;
    int div_starts = 0;
    int out0 = 0, out1 = 0;
    int model_last = 1;
    bit hold0 = 1'b0;
    logic [W-1:0] mq1 = '0, mr1 = '0;
    logic         me1 = 1'b0;

    typedef struct { logic [W-1:0] a; logic [W-1:0] b; } job_t;
    typedef struct { int id; int cyc; bit tie; } acc_t;
    typedef struct { int id; int cyc; logic [W-1:0] q; logic [W-1:0] r; logic e; } res_t;

    job_t pend0[$], pend1[$], sub0[$], sub1[$];
    acc_t acc_log[$];
    res_t res_log[$];

    div_arbiter #(.WIDTH(W)) u_dut (
        .clk_in             (clk),
        .rst_in             (rst),
        .req0_valid_in      (r0v),
        .req0_dividend_in   (r0a),
        .req0_divisor_in    (r0b),
        .req0_ready_out     (rdy0),
        .req1_valid_in      (r1v),
        .req1_dividend_in   (r1a),
        .req1_divisor_in    (r1b),
        .req1_ready_out     (rdy1),
        .res0_quotient_out  (q0),
        .res0_remainder_out (m0),
        .res0_error_out     (e0),
        .res0_valid_out     (v0),
        .res1_quotient_out  (q1),
        .res1_remainder_out (m1),
        .res1_error_out     (e1),
        .res1_valid_out     (v1),
        .busy_out           (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (u_dut.div_start_s) div_starts <= div_starts + 1;

    task automatic add_job(input int who, input logic [W-1:0] a, input logic [W-1:0] b);
        job_t j;
        j.a = a; j.b = b;
        if (who == 0) begin pend0.push_back(j); sub0.push_back(j); end
        else begin pend1.push_back(j); sub1.push_back(j); end
    endtask

    task automatic clear_logs();
        pend0.delete(); pend1.delete(); sub0.delete(); sub1.delete();
        acc_log.delete(); res_log.delete();
    endtask

    task automatic present0();
        if (pend0.size() > 0 && !(hold0 && out0 > 0)) begin
            r0v = 1'b1; r0a = pend0[0].a; r0b = pend0[0].b;
        end else begin
            r0v = 1'b0;
        end
    endtask

    task automatic present1();
        if (pend1.size() > 0) begin
            r1v = 1'b1; r1a = pend1[0].a; r1b = pend1[0].b;
        end else begin
            r1v = 1'b0;
        end
    endtask

    // Cycle-by-cycle requester model: samples at negedge, changes inputs just after posedge.
    task automatic run(input int budget, output bit timeout);
        acc_t ae;
        res_t re;
        timeout = 1'b1;
        @(posedge clk); #1;
        present0(); present1();
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (v0) begin re.id = 0; re.cyc = cyc; re.q = q0; re.r = m0; re.e = e0; res_log.push_back(re); out0--; end
            if (v1) begin re.id = 1; re.cyc = cyc; re.q = q1; re.r = m1; re.e = e1; res_log.push_back(re); out1--; end
            if (r0v && rdy0) begin ae.id = 0; ae.cyc = cyc; ae.tie = r1v; acc_log.push_back(ae); void'(pend0.pop_front()); out0++; end
            if (r1v && rdy1) begin ae.id = 1; ae.cyc = cyc; ae.tie = r0v; acc_log.push_back(ae); void'(pend1.pop_front()); out1++; end
            if (rdy0 && rdy1) ready_viol++;
            if ((rdy0 || rdy1) && busy) ready_viol++;
            if (v0) present0();
            if (v1) present1();
            if (pend0.size() == 0 && pend1.size() == 0 && out0 == 0 && out1 == 0) begin
                timeout = 1'b0;
                break;
            end
            @(posedge clk); #1;
            present0(); present1();
        end
        foreach (acc_log[i]) model_last = acc_log[i].id;
    endtask

    task automatic test_reset();
        @(posedge clk); #2;
        total++;
        if ({q0, m0, q1, m1, e0, e1, v0, v1, rdy0, rdy1, busy} !== '0) begin
            bad++; $display("FAIL reset_state: got %h want 0", {q0, m0, q1, m1, e0, e1, v0, v1, rdy0, rdy1, busy});
        end
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({v0, v1, busy} !== 3'b000) begin bad++; $display("FAIL idle_after_reset: got %b want 000", {v0, v1, busy}); end
    endtask

    task automatic test_simultaneous();
        bit to;
        clear_logs();
        add_job(0, 32'd1000, 32'd10);
        add_job(1, 32'd81, 32'd9);
        run(2 * (RES_LAT + 2) + 10, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL sim_timeout: got 1 want 0"); end
        total++;
        if (acc_log.size() != 2 || res_log.size() != 2) begin
            bad++; $display("FAIL sim_counts: got acc=%0d res=%0d want 2/2", acc_log.size(), res_log.size());
        end else begin
            total++; if (acc_log[0].id != 0 || acc_log[1].id != 1) begin bad++; $display("FAIL sim_order: got %0d,%0d want 0,1", acc_log[0].id, acc_log[1].id); end
            total++; if ({res_log[0].q, res_log[0].r, res_log[0].e} !== {32'd100, 32'd0, 1'b0}) begin bad++; $display("FAIL sim_res0: got %0d r%0d e%b want 100 r0 e0", res_log[0].q, res_log[0].r, res_log[0].e); end
            total++; if ({res_log[1].q, res_log[1].r, res_log[1].e} !== {32'd9, 32'd0, 1'b0}) begin bad++; $display("FAIL sim_res1: got %0d r%0d e%b want 9 r0 e0", res_log[1].q, res_log[1].r, res_log[1].e); end
        end
        total++; if (ready_viol != 0) begin bad++; $display("FAIL sim_ready_rule: got %0d violations want 0", ready_viol); end
    endtask

    task automatic test_round_robin();
        bit to;
        int exp_id[4];
        int k0, k1;
        job_t j;
        logic [W-1:0] eq, er;
`ifdef DIV_ARB_ROUND_ROBIN_EN
        exp_id = '{0, 1, 0, 1};
`else
        exp_id = '{0, 0, 0, 0};
`endif
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            add_job(0, $urandom, $urandom_range(1, 1000));
            add_job(1, $urandom, $urandom_range(1, 1000));
        end
        run(8 * (RES_LAT + 2) + 20, to);
        total++; if (to !== 1'b0 || acc_log.size() != 8) begin bad++; $display("FAIL rr_done: got to=%b acc=%0d want 0/8", to, acc_log.size()); end
        for (int i = 0; i < 4 && i < acc_log.size(); i++) begin
            total++; if (acc_log[i].id != exp_id[i]) begin bad++; $display("FAIL rr_grant%0d: got %0d want %0d", i, acc_log[i].id, exp_id[i]); end
        end
        for (int i = 0; i + 1 < acc_log.size(); i++) begin
            total++; if (acc_log[i+1].cyc - acc_log[i].cyc != DIV_LAT + 3) begin bad++; $display("FAIL back_to_back%0d: got %0d want %0d", i, acc_log[i+1].cyc - acc_log[i].cyc, DIV_LAT + 3); end
        end
        k0 = 0; k1 = 0;
        foreach (res_log[i]) begin
            if (res_log[i].id == 0) begin j = sub0[k0]; k0++; end
            else begin j = sub1[k1]; k1++; end
            eq = j.a / j.b; er = j.a % j.b;
            total++; if ({res_log[i].q, res_log[i].r, res_log[i].e} !== {eq, er, 1'b0}) begin bad++; $display("FAIL rr_result%0d: got %0d r%0d want %0d r%0d", i, res_log[i].q, res_log[i].r, eq, er); end
            if (res_log[i].id == 1) begin mq1 = eq; mr1 = er; me1 = 1'b0; end
        end
    endtask

    task automatic test_single();
        bit to;
        clear_logs();
        add_job(0, 32'd100, 32'd7);
        run(RES_LAT + 10, to);
        total++;
        if (to !== 1'b0 || res_log.size() != 1 || acc_log.size() != 1) begin
            bad++; $display("FAIL single_done: got to=%b res=%0d want 0/1", to, res_log.size());
        end else begin
            total++; if (res_log[0].id != 0) begin bad++; $display("FAIL single_id: got %0d want 0", res_log[0].id); end
            total++; if ({res_log[0].q, res_log[0].r, res_log[0].e} !== {32'd14, 32'd2, 1'b0}) begin bad++; $display("FAIL single_result: got %0d r%0d e%b want 14 r2 e0", res_log[0].q, res_log[0].r, res_log[0].e); end
            total++; if (res_log[0].cyc - acc_log[0].cyc != RES_LAT) begin bad++; $display("FAIL single_latency: got %0d want %0d", res_log[0].cyc - acc_log[0].cyc, RES_LAT); end
        end
        total++; if ({q1, m1, e1} !== {mq1, mr1, me1}) begin bad++; $display("FAIL single_res1_untouched: got %0d r%0d e%b want %0d r%0d e%b", q1, m1, e1, mq1, mr1, me1); end
    endtask

    task automatic test_div_zero();
        bit to;
        int starts_before;
        starts_before = div_starts;
        clear_logs();
        add_job(1, 32'd55, 32'd0);
        run(20, to);
        total++;
        if (to !== 1'b0 || res_log.size() != 1) begin
            bad++; $display("FAIL dz_done: got to=%b res=%0d want 0/1", to, res_log.size());
        end else begin
            total++; if (res_log[0].id != 1) begin bad++; $display("FAIL dz_id: got %0d want 1", res_log[0].id); end
            total++; if ({res_log[0].q, res_log[0].r, res_log[0].e} !== {32'd0, 32'd0, 1'b1}) begin bad++; $display("FAIL dz_result: got %0d r%0d e%b want 0 r0 e1", res_log[0].q, res_log[0].r, res_log[0].e); end
            total++; if (res_log[0].cyc - acc_log[0].cyc != 1) begin bad++; $display("FAIL dz_latency: got %0d want 1", res_log[0].cyc - acc_log[0].cyc); end
        end
        total++; if (div_starts != starts_before) begin bad++; $display("FAIL dz_no_start: got %0d starts want 0", div_starts - starts_before); end
    endtask

    task automatic test_reset_mid_wait();
        bit ok, to;
        int pulses;
        @(posedge clk); #1;
        r0v = 1'b1; r0a = 32'd12345; r0b = 32'd7;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rdy0) begin ok = 1'b1; break; end
        end
        total++; if (!ok) begin bad++; $display("FAIL mid_accept: got no ready want ready"); end
        @(posedge clk); #1; r0v = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        total++;
        if ({q0, m0, q1, m1, e0, e1, v0, v1, rdy0, rdy1, busy} !== '0) begin
            bad++; $display("FAIL mid_async_clear: got %h want 0", {q0, m0, q1, m1, e0, e1, v0, v1, rdy0, rdy1, busy});
        end
        @(negedge clk); rst = 1'b0;
        out0 = 0; out1 = 0; model_last = 1;
        pulses = 0;
        repeat (RES_LAT + 10) begin @(negedge clk); if (v0 || v1) pulses++; end
        total++; if (pulses != 0) begin bad++; $display("FAIL mid_no_pulse: got %0d pulses want 0", pulses); end
        clear_logs();
        add_job(0, 32'd9, 32'd3);
        run(RES_LAT + 10, to);
        total++;
        if (to !== 1'b0 || res_log.size() != 1) begin bad++; $display("FAIL mid_next_done: got to=%b want 0", to); end
        else if ({res_log[0].q, res_log[0].r, res_log[0].e} !== {32'd3, 32'd0, 1'b0}) begin
            bad++; $display("FAIL mid_next_result: got %0d r%0d e%b want 3 r0 e0", res_log[0].q, res_log[0].r, res_log[0].e);
        end
    endtask

    task automatic test_reissue();
        bit to;
        clear_logs();
        hold0 = 1'b1;
        add_job(0, 32'd20, 32'd4);
        add_job(0, 32'd50, 32'd5);
        run(2 * (RES_LAT + 2) + 10, to);
        hold0 = 1'b0;
        total++;
        if (to !== 1'b0 || res_log.size() != 2 || acc_log.size() != 2) begin
            bad++; $display("FAIL reissue_done: got to=%b res=%0d want 0/2", to, res_log.size());
        end else begin
            total++; if (acc_log[1].cyc - res_log[0].cyc != 1) begin bad++; $display("FAIL reissue_accept: got %0d want 1", acc_log[1].cyc - res_log[0].cyc); end
            total++; if ({res_log[1].q, res_log[1].r, res_log[1].e} !== {32'd10, 32'd0, 1'b0}) begin bad++; $display("FAIL reissue_result: got %0d r%0d e%b want 10 r0 e0", res_log[1].q, res_log[1].r, res_log[1].e); end
        end
    endtask

    task automatic test_random();
        bit to;
        int k0, k1, last, exp_g, exp_lat;
        int ac0[$], ac1[$];
        job_t j;
        logic [W-1:0] eq, er, b;
        logic ee;
        clear_logs();
        last = model_last;
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = $urandom;
                default: b = $urandom_range(1, 300);
            endcase
            add_job(i % 2, $urandom, b);
        end
        run(24 * (RES_LAT + 2) + 50, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL rand_timeout: got 1 want 0"); end
        foreach (acc_log[i]) begin
            if (acc_log[i].tie) begin
`ifdef DIV_ARB_ROUND_ROBIN_EN
                exp_g = 1 - last;
`else
                exp_g = 0;
`endif
                total++; if (acc_log[i].id != exp_g) begin bad++; $display("FAIL rand_tie%0d: got %0d want %0d", i, acc_log[i].id, exp_g); end
            end
            last = acc_log[i].id;
            if (acc_log[i].id == 0) ac0.push_back(acc_log[i].cyc); else ac1.push_back(acc_log[i].cyc);
        end
        k0 = 0; k1 = 0;
        foreach (res_log[i]) begin
            if (res_log[i].id == 0) begin
                j = sub0[k0]; exp_lat = res_log[i].cyc - ac0[k0]; k0++;
            end else begin
                j = sub1[k1]; exp_lat = res_log[i].cyc - ac1[k1]; k1++;
            end
            if (j.b == '0) begin eq = '0; er = '0; ee = 1'b1; end
            else begin eq = j.a / j.b; er = j.a % j.b; ee = 1'b0; end
            total++; if ({res_log[i].q, res_log[i].r, res_log[i].e} !== {eq, er, ee}) begin bad++; $display("FAIL rand_result%0d: got %h r%h e%b want %h r%h e%b", i, res_log[i].q, res_log[i].r, res_log[i].e, eq, er, ee); end
            total++; if (exp_lat != ((j.b == '0) ? 1 : RES_LAT)) begin bad++; $display("FAIL rand_latency%0d: got %0d want %0d", i, exp_lat, (j.b == '0) ? 1 : RES_LAT); end
        end
        total++; if (k0 != 12 || k1 != 12) begin bad++; $display("FAIL rand_count: got %0d/%0d want 12/12", k0, k1); end
        total++; if (ready_viol != 0) begin bad++; $display("FAIL rand_ready_rule: got %0d violations want 0", ready_viol); end
    endtask

    initial begin
        test_reset();
        test_simultaneous();
        test_round_robin();
        test_single();
        test_div_zero();
        test_reset_mid_wait();
        test_reissue();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_arbiter.md
# div_arbiter

Shares one iterative `divider` instance between two independent requesters (e.g. the x and y centroid paths of the tracking pipeline), so each frame's center-of-mass computation needs one divider instead of two. It accepts one divide job at a time and sequences the divider through issue and wait. It returns the quotient, remainder and error to the requester that issued the job, with a one-cycle valid pulse. Arbitration between simultaneous requests is round-robin (configurable).

## Interface
- `WIDTH`, 32: operand width; dividend, divisor, quotient and remainder are all `WIDTH` bits, unsigned.
- `clk_in`  in  1  system clock; all state on rising edge.
- `rst_in`  in  1  reset, asynchronous, active-high.
- `req0_valid_in` / `req1_valid_in`  in  1  requester i has a job pending; held until accepted.
- `req0_dividend_in` / `req1_dividend_in`  in  WIDTH  dividend, stable while valid.
- `req0_divisor_in` / `req1_divisor_in`  in  WIDTH  divisor, stable while valid.
- `req0_ready_out` / `req1_ready_out`  out  1  job accepted this cycle when valid && ready.
- `res0_quotient_out` / `res1_quotient_out`  out  WIDTH  last result for requester i.
- `res0_remainder_out` / `res1_remainder_out`  out  WIDTH  last remainder for requester i.
- `res0_error_out` / `res1_error_out`  out  1  last job had divisor 0.
- `res0_valid_out` / `res1_valid_out`  out  1  one-cycle pulse; the result outputs of requester i were updated.
- `busy_out`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, RETURN.
- **IDLE**
  - Grant select is combinational from valids and `last_grant`.
  - `reqG_ready_out` = 1 only for the granted requester, only in IDLE, and only if its valid is high.
  - On acceptance: latch operands and grant id, update `last_grant`.
  - Divisor 0 → RETURN directly. Otherwise → ISSUE.
- **ISSUE**: drive divider `data_valid_in` = 1 for exactly one cycle with the latched operands → WAIT.
- **WAIT**: hold until divider `data_valid_out`, then capture quotient, remainder and error → RETURN.
- **RETURN**
  - Write the captured values to the granted requester's `res*` outputs.
  - Pulse that requester's `res*_valid_out` for one cycle → IDLE.
  - The other requester's outputs are untouched.
- **Divisor 0**: the divider is never started. Result is quotient 0, remainder 0, error 1.
- **Both valid in IDLE**: grant the requester not equal to `last_grant`. `last_grant` resets to 1, so requester 0 wins the first tie.
- **Requester re-issuing on its pulse cycle**: a requester may raise valid in the same cycle as its `res*_valid_out` pulse. Its job is eligible in the following IDLE cycle.
- **Reset**
  - All `res*` outputs are 0.
  - All `ready`/`valid` outputs are 0, `busy_out` = 0.
  - State is IDLE, `last_grant` = 1.
  - Mid-job reset discards the job with no result pulse. The divider is reset by the same `rst_in`.

## Timing
- Acceptance happens in cycle A (valid && ready).
- ISSUE occurs in cycle A+1.
- Divider completes in cycle D (the divider's own latency).
- Capture happens in D; RETURN in D+1, with the `res*_valid_out` pulse in D+1. IDLE again in D+2.
- Divisor 0: RETURN in A+1 with the pulse in A+1, IDLE in A+2.
- Back-to-back throughput: one job per (divider latency + 3) cycles.
- `ready` is never high outside IDLE; at most one `ready` is high per cycle.

## Configuration
- `DIV_ARB_ROUND_ROBIN_EN` defined: round-robin tie-break as described above.
- `DIV_ARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority; requester 0 always wins a tie.
  - `last_grant` is not implemented.
  - Requester 1 can starve while requester 0 keeps valid high.

## Structure
- Package `div_arb_pkg`:
  - state enum `div_arb_state_t` (IDLE, ISSUE, WAIT, RETURN);
  - `grant_t` (1-bit requester id);
  - default `DIV_ARB_WIDTH` = 32.
- One sub-module: the existing `divider`, instantiated with `.WIDTH(WIDTH)`.
  - Its `error_out` is ORed into the captured error.
  - Its `busy_out` is used only as an assertion: it must be low in ISSUE.

## Test plan
- Single job: req0 100/7 → one `res0_valid_out` pulse with quotient 14, remainder 2, error 0. `res1_*` unchanged. Pulse occurs at D+1.
- Simultaneous: req0 1000/10 and req1 81/9 raised together → req0 is served first (quotient 100, rem 0), then req1 (quotient 9, rem 0). Exactly one `ready` per acceptance.
- Round-robin: both held valid for 4 jobs → grants alternate 0,1,0,1. With the macro undefined → 0,0,0,0.
- Divide by zero: req1 55/0 → `res1_valid_out` at A+1 with quotient 0, rem 0, error 1. Divider `data_valid_in` is never asserted.
- Reset mid-WAIT: `rst_in` pulsed during WAIT → all outputs 0 immediately (async) and no result pulse. The next job, 9/3, returns quotient 3, rem 0.
- Re-issue: req0 raises a new job (50/5) in its own pulse cycle → accepted in the next IDLE cycle, result quotient 10, rem 0.
